// File: rtl/gcd_pkg.sv
// gcd_pkg: state codes shared with the GCD controller FSM, default width and
// datapath select encodings.
package gcd_pkg;
  localparam int GCD_WIDTH = 16;
  typedef enum logic [4:0] {
    IDLE, INIT1, INIT2, INIT3, INIT4,
    CHECK1, CHECK2, CHECK3, CHECK4, CHECK5, CHECK6, CHECK7, CHECK8,
    EXCHANGE1, EXCHANGE2, EXCHANGE3,
    PRELOOP1, PRELOOP2,
    LOOP1, LOOP2, LOOP3, LOOP4, LOOP5, LOOP6, LOOP7, LOOP8, LOOP9, LOOP10, LOOP11,
    END1, END2
  } state_e;
  localparam logic [2:0] T_HOLD = 3'd0;
  localparam logic [2:0] T_A    = 3'd1;
  localparam logic [2:0] T_B    = 3'd2;
  localparam logic [2:0] T_SUB  = 3'd3;
  localparam logic [2:0] T_GE   = 3'd4;
  localparam logic [1:0] A_HOLD = 2'd0;
  localparam logic [1:0] A_B    = 2'd1;
  localparam logic [1:0] A_T    = 2'd2;
endpackage

// File: rtl/gcd_op_decode.sv
// gcd_op_decode: maps the controller state code to datapath register enables.
module gcd_op_decode
  import gcd_pkg::*;
(
  input  logic [4:0] state,
  output logic       ld_in,
  output logic [2:0] t_sel,
  output logic [1:0] a_sel,
  output logic       b_we,
  output logic       iter_clr,
  output logic       iter_inc,
  output logic       res_we,
  output logic       res_sel,
  output logic       err_chk
);
  assign ld_in    = state == IDLE;
  assign t_sel    = state inside {INIT1, CHECK3, EXCHANGE1, LOOP7} ? T_A :
                    state inside {CHECK1, CHECK5, LOOP10} ? T_B :
                    state inside {CHECK7, LOOP3} ? T_SUB :
                    state == LOOP5 ? T_GE : T_HOLD;
  assign a_sel    = state inside {EXCHANGE2, LOOP8} ? A_B :
                    state == LOOP4 ? A_T : A_HOLD;
  assign b_we     = state inside {EXCHANGE3, LOOP9};
  assign iter_clr = state == INIT2;
  assign iter_inc = state == LOOP1;
  assign res_we   = state inside {END1, END2};
  assign res_sel  = state == END2;
  assign err_chk  = state inside {INIT4, CHECK2};
endmodule

// File: rtl/gcd_datapath.sv
// gcd_datapath: operand/temporary registers for a subtract-and-swap Euclid GCD,
// sequenced by the external controller's state code.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH  = GCD_WIDTH,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        state,
  input  logic              load,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  output logic              flag_z1,
  output logic              flag_s1,
  output logic [WIDTH-1:0]  result,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ITER_W-1:0] iter_cnt
);
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [WIDTH:0] t_q, t_d, a_x, b_x;
  logic [ITER_W-1:0] iter_q;
  logic done_q, err_q;
  logic ld_in, b_we, iter_clr, iter_inc, res_we, res_sel, err_chk;
  logic [2:0] t_sel;
  logic [1:0] a_sel;
  gcd_op_decode u_dec (
    .state(state), .ld_in(ld_in), .t_sel(t_sel), .a_sel(a_sel), .b_we(b_we),
    .iter_clr(iter_clr), .iter_inc(iter_inc), .res_we(res_we), .res_sel(res_sel),
    .err_chk(err_chk)
  );
  assign a_x = {a_q[WIDTH-1], a_q};
  assign b_x = {b_q[WIDTH-1], b_q};
  // T is one bit wider than the operands so its top bit is a reliable sign for A-B
  always_comb
    t_d = t_sel == T_A ? a_x :
          t_sel == T_B ? b_x :
          t_sel == T_SUB ? a_x - b_x :
          t_sel == T_GE ? {{WIDTH{1'b0}}, !($signed(a_q) < $signed(b_q))} : t_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      t_q    <= '0;
      res_q  <= '0;
      iter_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      a_q    <= ld_in && load ? a_in : a_sel == A_B ? b_q : a_sel == A_T ? t_q[WIDTH-1:0] : a_q;
      b_q    <= ld_in && load ? b_in : b_we ? t_q[WIDTH-1:0] : b_q;
      t_q    <= t_d;
      iter_q <= iter_clr ? '0 : iter_inc && iter_q != '1 ? iter_q + ITER_W'(1) : iter_q;
      res_q  <= res_we ? (res_sel ? a_q | b_q : a_q) : res_q;
      done_q <= res_we;
      err_q  <= err_chk && t_q[WIDTH];
    end
  assign flag_z1  = t_q == '0;
  assign flag_s1  = t_q[WIDTH];
  assign result   = res_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = state != IDLE;
  assign iter_cnt = iter_q;
endmodule

// File: tb/tb_gcd_datapath.sv
// tb_gcd_datapath: plays the controller FSM and checks results against an arithmetic Euclid model.
module tb_gcd_datapath;
  import gcd_pkg::*;
  localparam int W = GCD_WIDTH;
  localparam int IW = 8;
  logic clk = 1'b0, reset = 1'b0, load = 1'b0;
  logic [4:0] state = IDLE;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic flag_z1, flag_s1, done, err, busy;
  logic [W-1:0] result;
  logic [IW-1:0] iter_cnt;
  int nvec = 0, nfail = 0;
  string cur = "reset";
  logic [W-1:0] loop4_a[$];
  logic [W-1:0] ex_a, ex_b;
  bit exch;

  always #5 clk = ~clk;

  gcd_datapath #(.WIDTH(W), .ITER_W(IW)) dut (
    .clk(clk), .reset(reset), .state(state), .load(load), .a_in(a_in), .b_in(b_in),
    .flag_z1(flag_z1), .flag_s1(flag_s1), .result(result), .done(done), .err(err),
    .busy(busy), .iter_cnt(iter_cnt)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s/%s: observed %0h expected %0h", cur, name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_gcd(input int a, input int b, output int g, output int it);
    int x = a, y = b, r;
    it = 0;
    while (y != 0) begin
      it += x / y;
      r = x % y;
      x = y;
      y = r;
    end
    g = x;
    if (it > (1 << IW) - 1) it = (1 << IW) - 1;
  endfunction

  function automatic logic [4:0] nxt(input logic [4:0] s, input logic z, input logic sg);
    case (s)
      INIT4, CHECK2:  return sg ? IDLE : 5'(s + 1);
      CHECK4, CHECK6: return z ? END2 : 5'(s + 1);
      CHECK8:         return sg ? EXCHANGE1 : PRELOOP1;
      LOOP6:          return z ? LOOP7 : LOOP1;
      LOOP11:         return z ? END1 : LOOP1;
      END1, END2:     return IDLE;
      default:        return 5'(s + 1);
    endcase
  endfunction

  // mode 0: plain run, 1: stray load during LOOP3, 2: reset asserted during LOOP4
  task automatic run(input int a, input int b, input int mode, input string tag);
    int g, it, cyc, spur;
    logic [4:0] st, nx;
    logic [W-1:0] prev;
    bit neg, aborted, stray_done;
    cur = tag;
    prev = result;
    neg = a < 0 || b < 0;
    ref_gcd(a, b, g, it);
    loop4_a = {};
    exch = 0;
    spur = 0;
    aborted = 0;
    stray_done = 0;
    state = IDLE;
    a_in = W'(a);
    b_in = W'(b);
    load = 1'b1;
    tick;
    load = 1'b0;
    st = INIT1;
    cyc = 0;
    while (st != IDLE && cyc < 5000) begin
      state = st;
      if (cyc == 0) chk("busy_run", busy, 1);
      if (mode == 2 && st == LOOP4) begin
        #2 reset = 1'b0;
        #1;
        chk("rst_a", dut.a_q, 0);
        chk("rst_b", dut.b_q, 0);
        chk("rst_t", dut.t_q, 0);
        chk("rst_result", result, 0);
        chk("rst_iter", iter_cnt, 0);
        chk("rst_z1", flag_z1, 1);
        chk("rst_s1", flag_s1, 0);
        chk("rst_done_err", {done, err}, 0);
        state = IDLE;
        tick;
        tick;
        chk("rst_hold_done_err", {done, err}, 0);
        reset = 1'b1;
        aborted = 1;
        break;
      end
      if (mode == 1 && st == LOOP3 && !stray_done) begin
        load = 1'b1;
        a_in = 16'd99;
        b_in = 16'd88;
      end
      nx = nxt(st, flag_z1, flag_s1);
      tick;
      load = 1'b0;
      if (mode == 1 && st == LOOP3 && !stray_done) begin
        stray_done = 1;
        chk("stray_load_a", dut.a_q, W'(a));
        chk("stray_load_b", dut.b_q, W'(b));
      end
      if (st == LOOP4) loop4_a.push_back(dut.a_q);
      if (st == EXCHANGE3) begin
        exch = 1;
        ex_a = dut.a_q;
        ex_b = dut.b_q;
      end
      if (nx != IDLE) spur += int'(done) + int'(err);
      st = nx;
      cyc++;
    end
    state = IDLE;
    if (aborted) return;
    chk("cycle_bound", st == IDLE, 1);
    chk("early_pulse", spur, 0);
    chk("busy_idle", busy, 0);
    if (neg) begin
      chk("err", err, 1);
      chk("done", done, 0);
      chk("result_kept", result, prev);
      chk("iter", iter_cnt, 0);
    end else begin
      chk("done", done, 1);
      chk("err", err, 0);
      chk("result", result, g);
      chk("iter", iter_cnt, it);
    end
    tick;
    chk("pulse_end", {done, err}, 0);
  endtask

  initial begin
    logic [W-1:0] exp4[5] = '{16'd30, 16'd12, 16'd6, 16'd6, 16'd0};
    logic zsave, ssave;
    int ra, rb;
    #3;
    chk("a", dut.a_q, 0);
    chk("b", dut.b_q, 0);
    chk("t", dut.t_q, 0);
    chk("result", result, 0);
    chk("iter", iter_cnt, 0);
    chk("done_err", {done, err}, 0);
    chk("z1", flag_z1, 1);
    chk("s1", flag_s1, 0);
    chk("busy", busy, 0);
    #5 reset = 1'b1;
    tick;

    run(48, 18, 0, "t1");
    chk("loop4_count", loop4_a.size(), 5);
    foreach (exp4[i]) chk("loop4_a", i < loop4_a.size() ? loop4_a[i] : '1, exp4[i]);
    chk("no_exchange", exch, 0);

    cur = "unused_code";
    zsave = flag_z1;
    ssave = flag_s1;
    state = 5'b11111;
    tick;
    state = IDLE;
    chk("result", result, 6);
    chk("iter", iter_cnt, 5);
    chk("flags", {flag_z1, flag_s1}, {zsave, ssave});
    chk("done_err", {done, err}, 0);

    run(18, 48, 0, "t2");
    chk("exchange", exch, 1);
    chk("ex_a", ex_a, 48);
    chk("ex_b", ex_b, 18);

    run(-5, 10, 0, "t4_neg_a");
    run(10, -1, 0, "t4_neg_b");
    run(0, 35, 0, "t3_a0");
    run(35, 0, 0, "t3_b0");
    run(0, 0, 0, "t3_both0");
    run(7, 7, 1, "t5");
    run(1000, 3, 2, "t6_reset");
    run(9, 6, 0, "t6_after");
    run(300, 1, 0, "saturate");
    run(32767, 32767, 0, "max_equal");
    run(32767, -32768, 0, "min_neg_b");

    for (int k = 0; k < 15; k++) begin
      ra = int'($urandom_range(0, 300));
      rb = int'($urandom_range(1, 300));
      if ($urandom_range(0, 7) == 0) ra = -int'($urandom_range(1, 500));
      if ($urandom_range(0, 5) == 0) rb = 0;
      run(ra, rb, 0, $sformatf("rand%0d_%0d_%0d", k, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/gcd_datapath.md
Name: gcd_datapath

Overview:
- Datapath stage driven by the 5-bit `state` code of the GCD controller FSM.
- Consumes `state` and returns `flag_z1` and `flag_s1` to the FSM.
- Holds operand registers A and B and temporary register T; computes gcd(a_in, b_in) by Euclid's algorithm using repeated subtraction and swap.
- Reports the result, a completion pulse, an error pulse and an iteration count.

Parameters:
- WIDTH, 16, operand and result width; operands are two's complement, so the legal range is 0..2^(WIDTH-1)-1.
- ITER_W, 8, width of the saturating subtraction counter.

Ports:
- clk  input  1  rising-edge clock, shared with the FSM.
- reset  input  1  asynchronous, active-low reset.
- state  input  5  registered FSM state code.
- load  input  1  start request, also routed to the FSM; acted on only when state=IDLE.
- a_in  input  WIDTH  operand A, signed.
- b_in  input  WIDTH  operand B, signed.
- flag_z1  output  1  combinational: T==0.
- flag_s1  output  1  combinational: T[WIDTH], the sign bit of T.
- result  output  WIDTH  registered gcd; holds until the next completion.
- done  output  1  one-cycle registered pulse on completion.
- err  output  1  one-cycle registered pulse on a negative-operand abort.
- busy  output  1  combinational: state!=IDLE.
- iter_cnt  output  ITER_W  number of subtractions in the last run; saturates at all-ones.

Behaviour:
- Reset (reset=0, asynchronous):
  - A, B, T, result, iter_cnt are 0; done and err are 0.
  - Consequently flag_z1=1 and flag_s1=0.
  - Reset mid-operation aborts with no done or err pulse.
- Register widths: A, B are WIDTH bits. T is WIDTH+1 bits. Subtraction T<=A-B is performed sign-extended to WIDTH+1 bits.
- Each micro-op below executes at the clock edge ending the cycle in which `state` equals the listed code. The FSM samples the flags during the following state.
  - IDLE (00000): if load, capture A<=a_in and B<=b_in. Otherwise hold all registers.
  - INIT1: T<=sext(A).
  - INIT2: iter_cnt<=0.
  - INIT3: no operation.
  - INIT4: if flag_s1 (A<0), err<=1; the FSM returns to IDLE.
  - CHECK1: T<=sext(B).
  - CHECK2: if flag_s1 (B<0), err<=1; the FSM aborts.
  - CHECK3: T<=A.
  - CHECK4: A==0 leads the FSM to END2.
  - CHECK5: T<=B.
  - CHECK6: B==0 leads the FSM to END2.
  - CHECK7: T<=A-B.
  - CHECK8: flag_s1 (A<B) leads the FSM to EXCHANGE1.
  - EXCHANGE1: T<=A.
  - EXCHANGE2: A<=B.
  - EXCHANGE3: B<=T[WIDTH-1:0]. Net effect: A and B are swapped.
  - PRELOOP1, PRELOOP2: no operation. Invariant on entry: A>=B>0.
  - LOOP1: iter_cnt<=iter_cnt+1, saturating.
  - LOOP2: no operation.
  - LOOP3: T<=A-B.
  - LOOP4: A<=T[WIDTH-1:0].
  - LOOP5: T<=(A<B) ? 0 : 1.
  - LOOP6: flag_z1 (remainder reached) leads to LOOP7; otherwise back to LOOP1.
  - LOOP7: T<=A.
  - LOOP8: A<=B.
  - LOOP9: B<=T[WIDTH-1:0].
  - LOOP10: T<=B.
  - LOOP11: flag_z1 leads to END1; otherwise back to LOOP1.
  - END1: result<=A, done<=1.
  - END2: result<=A|B (at least one operand is zero), done<=1.
- done and err return to 0 on the cycle after they are set.
- Any unused code (11111) performs no operation.
- Simultaneous events and error cases:
  - load outside IDLE is ignored.
  - A scan-injected state executes its micro-op unconditionally.
  - An abort leaves result unchanged.
- a_in=b_in=0 takes the END2 path with result=0.

Decomposition:
- Shared package gcd_pkg holds:
  - the 5-bit state code constants, IDLE..END2, shared with the FSM;
  - the default WIDTH.
- One sub-module, gcd_op_decode: purely combinational. Maps `state` to the register enables (ld_in, t_sel[2:0], a_sel, b_we, iter_clr, iter_inc, res_we, res_sel, err_chk) and is reusable in bench checkers.

Test Plan:
1. a=48, b=18, load pulse in IDLE:
   - required response: END1 path, result=6, done pulses once, err=0, iter_cnt=5;
   - at LOOP4, A takes the values 30, 12, 6, 6, 0 in order.
2. a=18, b=48: the CHECK8 exchange path is taken; A=48 and B=18 after EXCHANGE3; result=6, iter_cnt=5.
3. Zero operands:
   - a=0, b=35: END2, result=35;
   - a=35, b=0: END2, result=35;
   - a=0, b=0: result=0, iter_cnt=0.
4. Negative operands:
   - a=-5, b=10: err pulse in the cycle after INIT4, no done, result keeps its prior value;
   - a=10, b=-1: abort at CHECK2, err pulse.
5. a=7, b=7: no exchange, one subtraction, iter_cnt=1, result=7. A load pulse issued during LOOP3 is ignored; A and B are unaffected.
6. Start a=1000, b=3, assert reset=0 during LOOP4:
   - while reset is low: all registers 0, flag_z1=1, flag_s1=0, done=err=0;
   - after release, a=9, b=6: result=3.
